feature_epoch_scheduler: RTL and testbench

//  Sequences the feature extraction datapath one epoch at a time.
//  - Gates EPOCH_LENGTH samples into the extractor.
//  - Waits for the extractor's combined valid and latches all NUM_FEATURES 32-bit features.
//  - Streams the features one per beat over valid/ready to the classifier.
//  - Optionally re-arms for the next epoch.
//  - Owns the extractor's en line, so between epochs en is dropped, which resets the extractor's submodules.

---
 rtl/feature_epoch_scheduler.sv | 179 +++++++++++++++++
 tb/tb_feature_epoch_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_epoch_scheduler.sv
// Epoch sequencer for the feature extractor: gates samples in,
// captures the feature vector, streams it out word by word.
`timescale 1ns/1ps
module feature_epoch_scheduler #(
  parameter int EPOCH_LENGTH   = 256,
  parameter int NUM_FEATURES   = 27,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      continuous,
  input  logic [31:0]               sample_in,
  input  logic                      sample_valid,
  output logic                      fe_en,
  output logic [31:0]               fe_data,
  output logic                      fe_in_valid,
  input  logic                      fe_valid,
  input  logic [32*NUM_FEATURES-1:0] fe_features,
  output logic [31:0]               feat_data,
  output logic [4:0]                feat_idx,
  output logic                      feat_valid,
  input  logic                      feat_ready,
  output logic                      feat_last,
  output logic                      busy,
  output logic                      overflow,
  output logic                      timeout_err
);

  localparam int SW = $clog2(EPOCH_LENGTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SMAX = SW'(EPOCH_LENGTH - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0] ILAST = 5'(NUM_FEATURES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WAIT,
    S_CAPTURE,
    S_STREAM,
    S_RESTART
  } state_t;

  state_t        r_state;
  state_t        w_nxt;
  logic [SW-1:0] r_sample_cnt;
  logic [TW-1:0] r_tmo_cnt;
  logic [4:0]    r_idx;
  logic [31:0]   r_bank [NUM_FEATURES];
  logic          r_fe_en;
  logic [31:0]   r_fe_data;
  logic          r_fe_in_valid;
  logic [31:0]   r_feat_data;
  logic          r_feat_valid;
  logic          r_feat_last;
  logic          r_busy;
  logic          r_overflow;
  logic          r_timeout_err;
  logic          w_accept;
  logic          w_drop;
  logic [4:0]    w_idx_nxt;

  assign w_accept  = r_feat_valid && feat_ready;
  assign w_idx_nxt = r_idx + 5'd1;
  assign w_drop    = sample_valid &&
                     (r_state == S_WAIT || r_state == S_CAPTURE ||
                      r_state == S_STREAM || r_state == S_RESTART);

  // Next-state selection; stop overrides every other transition.
  always_comb begin
    w_nxt = r_state;
    if (stop) begin
      w_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:    if (start) w_nxt = S_COLLECT;
        S_COLLECT: if (sample_valid && r_sample_cnt == SMAX)
                     w_nxt = S_WAIT;
        S_WAIT: begin
          if (fe_valid)               w_nxt = S_CAPTURE;
          else if (r_tmo_cnt == TMAX) w_nxt = S_IDLE;
        end
        S_CAPTURE: w_nxt = S_STREAM;
        S_STREAM:  if (w_accept && r_idx == ILAST)
                     w_nxt = continuous ? S_RESTART : S_IDLE;
        S_RESTART: w_nxt = S_COLLECT;
        default:   w_nxt = S_IDLE;
      endcase
    end
  end

  // State, counters, feature bank and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_sample_cnt  <= '0;
      r_tmo_cnt     <= '0;
      r_idx         <= '0;
      r_fe_en       <= 1'b0;
      r_fe_data     <= '0;
      r_fe_in_valid <= 1'b0;
      r_feat_data   <= '0;
      r_feat_valid  <= 1'b0;
      r_feat_last   <= 1'b0;
      r_busy        <= 1'b0;
      r_overflow    <= 1'b0;
      r_timeout_err <= 1'b0;
      for (int k = 0; k < NUM_FEATURES; k++) r_bank[k] <= '0;
    end else begin
      r_state       <= w_nxt;
      r_busy        <= (w_nxt != S_IDLE);
      r_fe_en       <= (w_nxt == S_COLLECT) || (w_nxt == S_WAIT) ||
                       (w_nxt == S_CAPTURE);
      r_fe_in_valid <= 1'b0;

      if (!stop && r_state == S_COLLECT && sample_valid) begin
        r_fe_data     <= sample_in;
        r_fe_in_valid <= 1'b1;
        r_sample_cnt  <= r_sample_cnt + 1'b1;
      end

      if (!stop && r_state == S_WAIT)
        r_tmo_cnt <= r_tmo_cnt + 1'b1;

      if (w_nxt == S_COLLECT && r_state != S_COLLECT) begin
        r_sample_cnt  <= '0;
        r_tmo_cnt     <= '0;
        r_overflow    <= 1'b0;
        r_timeout_err <= 1'b0;
      end

      // A dropped sample in RESTART still flags, even as COLLECT begins.
      if (w_drop)
        r_overflow <= 1'b1;

      if (!stop && r_state == S_WAIT && !fe_valid && r_tmo_cnt == TMAX)
        r_timeout_err <= 1'b1;

      if (!stop && r_state == S_CAPTURE) begin
        for (int k = 0; k < NUM_FEATURES; k++)
          r_bank[k] <= fe_features[32*k +: 32];
        r_idx        <= '0;
        r_feat_data  <= fe_features[31:0];
        r_feat_last  <= (ILAST == 5'd0);
        r_feat_valid <= 1'b1;
      end

      if (!stop && r_state == S_STREAM && w_accept) begin
        if (r_idx == ILAST) begin
          r_feat_valid <= 1'b0;
          r_feat_last  <= 1'b0;
        end else begin
          r_idx       <= w_idx_nxt;
          r_feat_data <= r_bank[w_idx_nxt];
          r_feat_last <= (w_idx_nxt == ILAST);
        end
      end

      if (stop) begin
        r_feat_valid <= 1'b0;
        r_feat_last  <= 1'b0;
      end
    end
  end

  assign fe_en       = r_fe_en;
  assign fe_data     = r_fe_data;
  assign fe_in_valid = r_fe_in_valid;
  assign feat_data   = r_feat_data;
  assign feat_idx    = r_idx;
  assign feat_valid  = r_feat_valid;
  assign feat_last   = r_feat_last;
  assign busy        = r_busy;
  assign overflow    = r_overflow;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_feature_epoch_scheduler.sv
// Directed bench for feature_epoch_scheduler: stream tables plus
// hand-written timeout, overflow, continuous and abort sequences.
`timescale 1ns/1ps
module tb_feature_epoch_scheduler;
  localparam int NF = 27;
  localparam int EL = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic continuous = 1'b0;
  logic [31:0] sample_in = '0;
  logic sample_valid = 1'b0;
  logic fe_valid = 1'b0;
  logic [32*NF-1:0] fe_features = '0;
  logic feat_ready = 1'b0;

  logic fe_en, fe_in_valid, feat_valid, feat_last;
  logic busy, overflow, timeout_err;
  logic [31:0] fe_data, feat_data;
  logic [4:0] feat_idx;

  logic t_fe_en, t_fe_in_valid, t_feat_valid, t_feat_last;
  logic t_busy, t_overflow, t_timeout_err;
  logic [31:0] t_fe_data, t_feat_data;
  logic [4:0] t_feat_idx;

  feature_epoch_scheduler u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .continuous(continuous), .sample_in(sample_in),
    .sample_valid(sample_valid), .fe_en(fe_en), .fe_data(fe_data),
    .fe_in_valid(fe_in_valid), .fe_valid(fe_valid),
    .fe_features(fe_features), .feat_data(feat_data),
    .feat_idx(feat_idx), .feat_valid(feat_valid),
    .feat_ready(feat_ready), .feat_last(feat_last), .busy(busy),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  feature_epoch_scheduler #(.TIMEOUT_CYCLES(64)) u_tmo (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .continuous(continuous), .sample_in(sample_in),
    .sample_valid(sample_valid), .fe_en(t_fe_en),
    .fe_data(t_fe_data), .fe_in_valid(t_fe_in_valid),
    .fe_valid(1'b0), .fe_features(fe_features),
    .feat_data(t_feat_data), .feat_idx(t_feat_idx),
    .feat_valid(t_feat_valid), .feat_ready(feat_ready),
    .feat_last(t_feat_last), .busy(t_busy),
    .overflow(t_overflow), .timeout_err(t_timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } vec_t;

  vec_t tbl[$];
  int n_run = 0;
  int n_fail = 0;
  int acc;
  int lowc;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0; stop = 1'b0; sample_valid = 1'b0;
    fe_valid = 1'b0; feat_ready = 1'b0; continuous = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic set_feat(input int off);
    for (int k = 0; k < NF; k++)
      fe_features[32*k +: 32] = 32'(k*16 + off);
  endtask

  task automatic fill_tbl(input bit toggle, input int off);
    tbl.delete();
    if (toggle) begin
      for (int i = 0; i < 2*NF; i++)
        tbl.push_back('{ready: 1'(i % 2), idx: 5'(i/2),
                        data: 32'((i/2)*16 + off),
                        last: ((i/2) == NF-1)});
    end else begin
      for (int i = 0; i < NF; i++)
        tbl.push_back('{ready: 1'b1, idx: 5'(i),
                        data: 32'(i*16 + off), last: (i == NF-1)});
    end
  endtask

  task automatic apply_tbl();
    acc = 0;
    foreach (tbl[i]) begin
      chk("beat_valid", feat_valid, 1);
      chk("beat_idx", feat_idx, tbl[i].idx);
      chk("beat_data", feat_data, tbl[i].data);
      chk("beat_last", feat_last, tbl[i].last);
      feat_ready = tbl[i].ready;
      if (feat_valid && feat_ready) acc++;
      step();
    end
    feat_ready = 1'b0;
  endtask

  task automatic collect(input bit do_start, input int n);
    if (do_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_fe_en", fe_en, 1);
    end
    for (int i = 0; i < n; i++) begin
      sample_in = 32'(i*7 - 500);
      sample_valid = 1'b1;
      step();
      chk("fwd_valid", fe_in_valid, 1);
      chk("fwd_data", fe_data, 32'(i*7 - 500));
    end
    sample_valid = 1'b0;
  endtask

  task automatic finish_wait(input int gap);
    repeat (gap) step();
    chk("wait_in_valid", fe_in_valid, 0);
    chk("wait_fe_en", fe_en, 1);
    chk("wait_busy", busy, 1);
    fe_valid = 1'b1;
    step();
    fe_valid = 1'b0;
    chk("capture_valid", feat_valid, 0);
    chk("capture_fe_en", fe_en, 1);
    step();
    chk("stream_fe_en", fe_en, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    set_feat(1);
    do_reset();
    chk("rst_fe_en", fe_en, 0);
    chk("rst_fe_data", fe_data, 0);
    chk("rst_in_valid", fe_in_valid, 0);
    chk("rst_feat_data", feat_data, 0);
    chk("rst_feat_idx", feat_idx, 0);
    chk("rst_feat_valid", feat_valid, 0);
    chk("rst_feat_last", feat_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_timeout", timeout_err, 0);

    // single epoch, always ready
    collect(1, EL);
    finish_wait(300);
    fill_tbl(0, 1);
    apply_tbl();
    chk("t1_beats", acc, NF);
    chk("t1_busy", busy, 0);
    chk("t1_fe_en", fe_en, 0);
    chk("t1_valid_end", feat_valid, 0);
    chk("t1_overflow", overflow, 0);

    // backpressure, ready toggling
    do_reset();
    collect(1, EL);
    finish_wait(300);
    fill_tbl(1, 1);
    apply_tbl();
    chk("t2_beats", acc, NF);
    chk("t2_busy", busy, 0);
    chk("t2_valid_end", feat_valid, 0);

    // timeout on the 64-cycle instance
    do_reset();
    collect(1, EL);
    repeat (63) step();
    chk("t3_busy_63", t_busy, 1);
    chk("t3_tmo_63", t_timeout_err, 0);
    step();
    chk("t3_busy_64", t_busy, 0);
    chk("t3_tmo_64", t_timeout_err, 1);
    chk("t3_fe_en_64", t_fe_en, 0);
    step();
    chk("t3_tmo_sticky", t_timeout_err, 1);

    // overflow: idle samples ignored, WAIT samples flagged
    do_reset();
    sample_valid = 1'b1;
    step();
    step();
    sample_valid = 1'b0;
    chk("t4_idle_ovf", overflow, 0);
    chk("t4_idle_fwd", fe_in_valid, 0);
    collect(1, EL);
    step();
    for (int i = 0; i < 10; i++) begin
      sample_valid = 1'b1;
      step();
      chk("t4_drop_fwd", fe_in_valid, 0);
    end
    sample_valid = 1'b0;
    chk("t4_ovf_set", overflow, 1);
    chk("t4_wait_busy", busy, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t4_stop_busy", busy, 0);
    chk("t4_ovf_sticky", overflow, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_ovf_clear", overflow, 0);
    chk("t4_restart_busy", busy, 1);

    // continuous: two epochs with one RESTART cycle between
    do_reset();
    continuous = 1'b1;
    collect(1, EL);
    finish_wait(50);
    lowc = 0;
    acc = 0;
    feat_ready = 1'b1;
    for (int c = 0; c < 100 && fe_en == 1'b0; c++) begin
      lowc++;
      if (feat_valid && feat_ready) acc++;
      step();
    end
    feat_ready = 1'b0;
    continuous = 1'b0;
    chk("t5_fe_en_low", lowc, NF + 1);
    chk("t5_beats1", acc, NF);
    chk("t5_busy_collect", busy, 1);
    set_feat(2);
    collect(0, EL);
    finish_wait(40);
    fill_tbl(0, 2);
    apply_tbl();
    chk("t5_beats2", acc, NF);
    chk("t5_busy_end", busy, 0);
    set_feat(1);

    // stop mid-stream at idx 5
    do_reset();
    collect(1, EL);
    finish_wait(20);
    feat_ready = 1'b1;
    for (int c = 0; c < 40 && feat_idx != 5'd5; c++) step();
    chk("t6_at_idx5", feat_idx, 5);
    stop = 1'b1;
    step();
    stop = 1'b0;
    feat_ready = 1'b0;
    chk("t6_stop_valid", feat_valid, 0);
    chk("t6_stop_busy", busy, 0);
    chk("t6_stop_fe_en", fe_en, 0);

    // async reset mid-collect
    do_reset();
    collect(1, 100);
    chk("t6_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("t6_ar_fe_en", fe_en, 0);
    chk("t6_ar_in_valid", fe_in_valid, 0);
    chk("t6_ar_fe_data", fe_data, 0);
    chk("t6_ar_busy", busy, 0);
    chk("t6_ar_valid", feat_valid, 0);
    chk("t6_ar_ovf", overflow, 0);
    chk("t6_ar_tmo", timeout_err, 0);
    step();
    rst = 1'b0;
    step();
    chk("t6_after_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
